// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing for the 5-stage TSC core: per-cycle stall/flush/PC-write decisions,
// data-memory wait tracking with timeout, and saturating performance counters.
module pipeline_hazard_controller #(
  parameter int WORD_SIZE    = 16,
  parameter int CNT_WIDTH    = 16,
  parameter int DMEM_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           rs_ID,
  input  logic [1:0]           rt_ID,
  input  logic                 use_rs_ID,
  input  logic                 use_rt_ID,
  input  logic                 jpr_ID,
  input  logic                 jump_redirect_ID,
  input  logic [1:0]           write_reg_addr_EX,
  input  logic                 RegWrite_EX,
  input  logic                 d_readM_EX,
  input  logic [1:0]           write_reg_addr_MEM,
  input  logic                 RegWrite_MEM,
  input  logic                 d_readM_MEM,
  input  logic                 d_writeM_MEM,
  input  logic                 d_ready,
  input  logic                 i_ready,
  input  logic                 mispredict_EX,
  input  logic                 is_halted_WB,
  input  logic                 inst_valid_WB,
  output logic                 pc_write,
  output logic                 stall_IF_ID,
  output logic                 stall_ID_EX,
  output logic                 stall_EX_MEM,
  output logic                 stall_MEM_WB,
  output logic                 flush_IF_ID,
  output logic                 flush_ID_EX,
  output logic                 flush_EX_MEM,
  output logic                 flush_MEM_WB,
  output logic                 halted,
  output logic                 mem_error,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] retired_count,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  if (DMEM_TIMEOUT < 1 || DMEM_TIMEOUT > 255 || WORD_SIZE < 1) begin : g_param_check
    $error("pipeline_hazard_controller: DMEM_TIMEOUT must be 1..255 and WORD_SIZE positive");
  end

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DWAIT = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [7:0]           LP_TIMEOUT = 8'(DMEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LP_CNT_MAX = '1;

  logic [1:0]           r_state;
  logic [7:0]           r_wait_cnt;
  logic                 r_halted;
  logic                 r_mem_error;
  logic [CNT_WIDTH-1:0] r_cycle_cnt;
  logic [CNT_WIDTH-1:0] r_retired_cnt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  logic w_dmem_miss;
  logic w_load_use;
  logic w_jpr_haz;
  logic w_flush_event;

  assign w_dmem_miss = (d_readM_MEM | d_writeM_MEM) & ~d_ready;
  assign w_load_use  = d_readM_EX & RegWrite_EX &
                       ((use_rs_ID & (write_reg_addr_EX == rs_ID)) |
                        (use_rt_ID & (write_reg_addr_EX == rt_ID)));
  // JPR needs rs in ID, so any EX writer or a MEM load still in flight must be waited out
  assign w_jpr_haz   = jpr_ID &
                       ((RegWrite_EX & (write_reg_addr_EX == rs_ID)) |
                        (d_readM_MEM & RegWrite_MEM & (write_reg_addr_MEM == rs_ID)));

  always_comb begin
    pc_write      = 1'b1;
    stall_IF_ID   = 1'b0;
    stall_ID_EX   = 1'b0;
    stall_EX_MEM  = 1'b0;
    stall_MEM_WB  = 1'b0;
    flush_IF_ID   = 1'b0;
    flush_ID_EX   = 1'b0;
    flush_EX_MEM  = 1'b0;
    flush_MEM_WB  = 1'b0;
    w_flush_event = 1'b0;
    if (!reset_n || r_state == ST_HALT) begin
      pc_write     = 1'b0;
      flush_IF_ID  = 1'b1;
      flush_ID_EX  = 1'b1;
      flush_EX_MEM = 1'b1;
      flush_MEM_WB = 1'b1;
    end else if (w_dmem_miss) begin
      pc_write     = 1'b0;
      stall_IF_ID  = 1'b1;
      stall_ID_EX  = 1'b1;
      stall_EX_MEM = 1'b1;
      flush_MEM_WB = 1'b1;
    end else if (mispredict_EX) begin
      flush_IF_ID   = 1'b1;
      flush_ID_EX   = 1'b1;
      w_flush_event = 1'b1;
    end else if (w_load_use || w_jpr_haz) begin
      pc_write    = 1'b0;
      stall_IF_ID = 1'b1;
      flush_ID_EX = 1'b1;
    end else if (jump_redirect_ID) begin
      flush_IF_ID   = 1'b1;
      w_flush_event = 1'b1;
    end else if (!i_ready) begin
      pc_write    = 1'b0;
      flush_IF_ID = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= 8'd0;
      r_halted      <= 1'b0;
      r_mem_error   <= 1'b0;
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (is_halted_WB) begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_dmem_miss) begin
            r_state    <= ST_DWAIT;
            r_wait_cnt <= 8'd1;
          end
        end
        ST_DWAIT: begin
          if (d_ready) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
          end else if (r_wait_cnt == LP_TIMEOUT) begin
            r_state     <= ST_HALT;
            r_halted    <= 1'b1;
            r_mem_error <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_RUN;
      endcase

      // Counters freeze once halted but still see the cycle that enters HALT
      if (r_state != ST_HALT) begin
        if (r_cycle_cnt != LP_CNT_MAX)
          r_cycle_cnt <= r_cycle_cnt + LP_CNT_ONE;
        if (inst_valid_WB && !stall_MEM_WB && r_retired_cnt != LP_CNT_MAX)
          r_retired_cnt <= r_retired_cnt + LP_CNT_ONE;
        if (!pc_write && r_stall_cnt != LP_CNT_MAX)
          r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
        if (w_flush_event && r_flush_cnt != LP_CNT_MAX)
          r_flush_cnt <= r_flush_cnt + LP_CNT_ONE;
      end
    end
  end

  assign halted        = r_halted;
  assign mem_error     = r_mem_error;
  assign cycle_count   = r_cycle_cnt;
  assign retired_count = r_retired_cnt;
  assign stall_count   = r_stall_cnt;
  assign flush_count   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a table of single-cycle control vectors
// followed by hand-written multi-cycle sequences (DMEM wait, timeout, halt, saturation).
module tb_pipeline_hazard_controller;

  localparam int CW = 16;

  localparam logic [8:0] E_NORMAL = 9'b1_0000_0000;
  localparam logic [8:0] E_HAZ    = 9'b0_1000_0100;
  localparam logic [8:0] E_MISP   = 9'b1_0000_1100;
  localparam logic [8:0] E_JR     = 9'b1_0000_1000;
  localparam logic [8:0] E_IMISS  = 9'b0_0000_1000;
  localparam logic [8:0] E_DMISS  = 9'b0_1110_0001;
  localparam logic [8:0] E_HALT   = 9'b0_0000_1111;

  logic clk = 1'b0;
  logic reset_n;
  logic [1:0] rs_ID, rt_ID, write_reg_addr_EX, write_reg_addr_MEM;
  logic use_rs_ID, use_rt_ID, jpr_ID, jump_redirect_ID;
  logic RegWrite_EX, d_readM_EX, RegWrite_MEM, d_readM_MEM, d_writeM_MEM;
  logic d_ready, i_ready, mispredict_EX, is_halted_WB, inst_valid_WB;
  logic pc_write, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB;
  logic halted, mem_error;
  logic [CW-1:0] cycle_count, retired_count, stall_count, flush_count;
  logic [8:0] w_out;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_controller #(.WORD_SIZE(16), .CNT_WIDTH(CW), .DMEM_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .use_rs_ID(use_rs_ID), .use_rt_ID(use_rt_ID),
    .jpr_ID(jpr_ID), .jump_redirect_ID(jump_redirect_ID),
    .write_reg_addr_EX(write_reg_addr_EX), .RegWrite_EX(RegWrite_EX), .d_readM_EX(d_readM_EX),
    .write_reg_addr_MEM(write_reg_addr_MEM), .RegWrite_MEM(RegWrite_MEM),
    .d_readM_MEM(d_readM_MEM), .d_writeM_MEM(d_writeM_MEM),
    .d_ready(d_ready), .i_ready(i_ready), .mispredict_EX(mispredict_EX),
    .is_halted_WB(is_halted_WB), .inst_valid_WB(inst_valid_WB),
    .pc_write(pc_write), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
    .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
    .flush_EX_MEM(flush_EX_MEM), .flush_MEM_WB(flush_MEM_WB),
    .halted(halted), .mem_error(mem_error),
    .cycle_count(cycle_count), .retired_count(retired_count),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  assign w_out = {pc_write, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
                  flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB};

  typedef struct {
    string      name;
    logic [1:0] rs;   logic urs;
    logic [1:0] rt;   logic urt;
    logic       jpr;  logic jr;
    logic [1:0] wex;  logic rwex; logic rdex;
    logic [1:0] wmem; logic rwmem; logic rdmem; logic wrmem;
    logic       dr;   logic ir;   logic misp;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm,
                     input logic [1:0] rs, input logic urs, input logic [1:0] rt, input logic urt,
                     input logic jpr, input logic jr,
                     input logic [1:0] wex, input logic rwex, input logic rdex,
                     input logic [1:0] wmem, input logic rwmem, input logic rdmem, input logic wrmem,
                     input logic dr, input logic ir, input logic misp, input logic [8:0] exp);
    vec_t v;
    v.name = nm; v.rs = rs; v.urs = urs; v.rt = rt; v.urt = urt; v.jpr = jpr; v.jr = jr;
    v.wex = wex; v.rwex = rwex; v.rdex = rdex; v.wmem = wmem; v.rwmem = rwmem;
    v.rdmem = rdmem; v.wrmem = wrmem; v.dr = dr; v.ir = ir; v.misp = misp; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    rs_ID = v.rs; use_rs_ID = v.urs; rt_ID = v.rt; use_rt_ID = v.urt;
    jpr_ID = v.jpr; jump_redirect_ID = v.jr;
    write_reg_addr_EX = v.wex; RegWrite_EX = v.rwex; d_readM_EX = v.rdex;
    write_reg_addr_MEM = v.wmem; RegWrite_MEM = v.rwmem; d_readM_MEM = v.rdmem;
    d_writeM_MEM = v.wrmem; d_ready = v.dr; i_ready = v.ir; mispredict_EX = v.misp;
  endtask

  task automatic idle();
    rs_ID = 2'd0; rt_ID = 2'd0; use_rs_ID = 1'b0; use_rt_ID = 1'b0;
    jpr_ID = 1'b0; jump_redirect_ID = 1'b0;
    write_reg_addr_EX = 2'd0; RegWrite_EX = 1'b0; d_readM_EX = 1'b0;
    write_reg_addr_MEM = 2'd0; RegWrite_MEM = 1'b0; d_readM_MEM = 1'b0; d_writeM_MEM = 1'b0;
    d_ready = 1'b1; i_ready = 1'b1; mispredict_EX = 1'b0;
    is_halted_WB = 1'b0; inst_valid_WB = 1'b0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_load_use();
    rs_ID = 2'd1; use_rs_ID = 1'b1;
    write_reg_addr_EX = 2'd1; RegWrite_EX = 1'b1; d_readM_EX = 1'b1;
  endtask

  // Leaves the bench at a falling edge, reset released, inputs idle, no counted cycle yet
  task automatic do_reset();
    @(negedge clk);
    idle();
    reset_n = 1'b0;
    #1 check("reset_comb_outputs", 32'(w_out), 32'(E_HALT));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_mem_error", 32'(mem_error), 32'd0);
    check("reset_counters", {cycle_count, retired_count} | {stall_count, flush_count}, 32'd0);
  endtask

  logic [CW-1:0] s0, f0, r0, c0;

  initial begin
    idle();
    reset_n = 1'b0;

    add("normal",        0,0, 0,0, 0,0, 0,0,0, 0,0,0,0, 1,1,0, E_NORMAL);
    add("lu_rs",         1,1, 0,0, 0,0, 1,1,1, 0,0,0,0, 1,1,0, E_HAZ);
    add("lu_rt",         0,0, 2,1, 0,0, 2,1,1, 0,0,0,0, 1,1,0, E_HAZ);
    add("lu_rs_unused",  1,0, 0,0, 0,0, 1,1,1, 0,0,0,0, 1,1,0, E_NORMAL);
    add("ld_no_regwr",   1,1, 0,0, 0,0, 1,0,1, 0,0,0,0, 1,1,0, E_NORMAL);
    add("alu_ex_nojpr",  1,1, 0,0, 0,0, 1,1,0, 0,0,0,0, 1,1,0, E_NORMAL);
    add("lu_addr_diff",  2,1, 3,1, 0,0, 1,1,1, 0,0,0,0, 1,1,0, E_NORMAL);
    add("jpr_ex_alu",    1,1, 0,0, 1,0, 1,1,0, 0,0,0,0, 1,1,0, E_HAZ);
    add("jpr_mem_load",  3,1, 0,0, 1,0, 0,0,0, 3,1,1,0, 1,1,0, E_HAZ);
    add("jpr_mem_alu",   3,1, 0,0, 1,0, 0,0,0, 3,1,0,0, 1,1,0, E_NORMAL);
    add("jpr_ex_noregwr",2,1, 0,0, 1,0, 2,0,0, 0,0,0,0, 1,1,0, E_NORMAL);
    add("misp_over_lu",  1,1, 0,0, 0,0, 1,1,1, 0,0,0,0, 1,1,1, E_MISP);
    add("jump_redirect", 0,0, 0,0, 0,1, 0,0,0, 0,0,0,0, 1,1,0, E_JR);
    add("jr_over_imiss", 0,0, 0,0, 0,1, 0,0,0, 0,0,0,0, 1,0,0, E_JR);
    add("imem_miss",     0,0, 0,0, 0,0, 0,0,0, 0,0,0,0, 1,0,0, E_IMISS);
    add("lu_over_jr",    1,1, 0,0, 0,1, 1,1,1, 0,0,0,0, 1,1,0, E_HAZ);
    add("lu_over_imiss", 1,1, 0,0, 0,0, 1,1,1, 0,0,0,0, 1,0,0, E_HAZ);
    add("misp_over_jr",  0,0, 0,0, 0,1, 0,0,0, 0,0,0,0, 1,1,1, E_MISP);
    add("dmiss_over_all",1,1, 0,0, 0,1, 1,1,1, 0,0,0,1, 0,1,1, E_DMISS);
    add("after_dmiss",   0,0, 0,0, 0,0, 0,0,0, 0,0,0,0, 1,1,0, E_NORMAL);

    do_reset();
    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1 check(vecs[i].name, 32'(w_out), 32'(vecs[i].exp));
    end

    // Load-use stalls for exactly one cycle
    do_reset();
    set_load_use();
    #1 check("lu_seq_out", 32'(w_out), 32'(E_HAZ));
    @(negedge clk);
    idle();
    #1;
    check("lu_seq_release", 32'(w_out), 32'(E_NORMAL));
    check("lu_seq_stall_cnt", 32'(stall_count), 32'd1);

    // Mispredict beats the load-use hazard and is counted as a flush
    s0 = stall_count; f0 = flush_count;
    @(negedge clk);
    set_load_use();
    mispredict_EX = 1'b1;
    #1 check("misp_lu_out", 32'(w_out), 32'(E_MISP));
    @(negedge clk);
    idle();
    jump_redirect_ID = 1'b1;
    #1;
    check("misp_flush_cnt", 32'(flush_count), 32'(f0 + 16'd1));
    check("misp_stall_cnt", 32'(stall_count), 32'(s0));
    @(negedge clk);
    idle();
    #1 check("jr_flush_cnt", 32'(flush_count), 32'(f0 + 16'd2));

    // DMEM read miss for three cycles; WB halt during DWAIT is ignored
    do_reset();
    r0 = retired_count; s0 = stall_count;
    d_readM_MEM = 1'b1; d_ready = 1'b0;
    #1 check("dmiss_c1", 32'(w_out), 32'(E_DMISS));
    @(negedge clk);
    is_halted_WB = 1'b1;
    #1 check("dmiss_c2", 32'(w_out), 32'(E_DMISS));
    @(negedge clk);
    is_halted_WB = 1'b0;
    #1 check("dmiss_c3", 32'(w_out), 32'(E_DMISS));
    @(negedge clk);
    d_ready = 1'b1;
    #1;
    check("dmiss_stall_cnt", 32'(stall_count), 32'(s0 + 16'd3));
    check("dmiss_ready_out", 32'(w_out), 32'(E_NORMAL));
    check("dwait_halt_ignored", 32'(halted), 32'd0);
    check("dmiss_retired_same", 32'(retired_count), 32'(r0));
    @(negedge clk);
    idle();
    inst_valid_WB = 1'b1;
    @(negedge clk);
    idle();
    #1;
    check("retire_after_dwait", 32'(retired_count), 32'(r0 + 16'd1));
    check("run_after_dwait", 32'(halted), 32'd0);

    // DMEM timeout: RUN->DWAIT(1), counts 2..4, then HALT on the fifth edge
    do_reset();
    d_readM_MEM = 1'b1; d_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("timeout_not_yet", 32'({halted, mem_error}), 32'd0);
    @(negedge clk);
    #1;
    check("timeout_mem_error", 32'(mem_error), 32'd1);
    check("timeout_halted", 32'(halted), 32'd1);
    check("timeout_out", 32'(w_out), 32'(E_HALT));
    check("timeout_cycle_cnt", 32'(cycle_count), 32'd5);
    check("timeout_stall_cnt", 32'(stall_count), 32'd5);
    d_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("timeout_cycle_frozen", 32'(cycle_count), 32'd5);
    check("timeout_stall_frozen", 32'(stall_count), 32'd5);
    check("timeout_sticky", 32'(w_out), 32'(E_HALT));

    // HLT retirement
    do_reset();
    is_halted_WB = 1'b1; inst_valid_WB = 1'b1;
    @(negedge clk);
    idle();
    #1;
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_out", 32'(w_out), 32'(E_HALT));
    check("hlt_retired", 32'(retired_count), 32'd1);
    check("hlt_mem_error", 32'(mem_error), 32'd0);
    inst_valid_WB = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("hlt_retired_frozen", 32'(retired_count), 32'd1);
    check("hlt_sticky", 32'(halted), 32'd1);
    do_reset();
    #1 check("post_reset_out", 32'(w_out), 32'(E_NORMAL));

    // Cycle counter saturation
    do_reset();
    repeat (65534) @(negedge clk);
    #1 check("cycle_cnt_fffe", 32'(cycle_count), 32'h0000_FFFE);
    c0 = cycle_count;
    repeat (70000 - 65534) @(negedge clk);
    #1;
    check("cycle_cnt_sat", 32'(cycle_count), 32'h0000_FFFF);
    check("cycle_cnt_progressed", 32'(cycle_count - c0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
